fetch_unit: RTL

Instruction fetch stage that produces the stream consumed by the instruction queue: it requests aligned 64-bit fetch blocks from the I-cache and packs one or two `pci_t` entries per block. It pushes them through the queue's `enq`/`in`/`in1`/`num_enq` port, honouring `full` backpressure. On a `flush_t` redirect it restarts at the flush target and discards any in-flight fetch. It sits between the I-cache and the instruction queue at the head of the pipeline.

---
 rtl/fetch_unit_pkg.sv | 53 +++++
 rtl/fetch_unit_pci_pack.sv | 19 +
 rtl/fetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: queue entry, redirect request, FSM states and opcodes.
package fetch_unit_pkg;

    localparam logic [31:0] FETCH_BYTES = 32'd8;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        PUSH  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef enum logic [6:0] {
        op_load  = 7'b0000011,
        op_imm   = 7'b0010011,
        op_auipc = 7'b0010111,
        op_store = 7'b0100011,
        op_reg   = 7'b0110011,
        op_lui   = 7'b0110111,
        op_br    = 7'b1100011,
        op_jalr  = 7'b1100111,
        op_jal   = 7'b1101111,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } flush_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] instruction;
        rv32i_opcode opcode;
        logic        br_pred;
    } pci_t;

    // Idle queue entry: decodes as an addi-class no-op.
    localparam pci_t PCI_IDLE = '{
        pc:          32'd0,
        next_pc:     32'd0,
        instruction: 32'd0,
        opcode:      op_imm,
        br_pred:     1'b0
    };

    // Fetch block base address containing byte address a.
    function automatic logic [31:0] block_addr(input logic [31:0] a);
        return {a[31:3], 3'b000};
    endfunction

endpackage

// File: rtl/fetch_unit_pci_pack.sv
// Packs one fetched instruction word and its address into a queue entry.
module pci_pack
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output pci_t        pci
);

    // No prediction: fall-through next PC, opcode taken from the low bits.
    always_comb begin
        pci             = PCI_IDLE;
        pci.pc          = pc;
        pci.instruction = instr;
        pci.opcode      = rv32i_opcode'(instr[6:0]);
        pci.next_pc     = pc + INSTR_BYTES;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads 64-bit blocks from the I-cache and pushes one or
// two entries per block into the instruction queue, with flush redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  flush_t      flush,
    input  logic        iq_full,
    output logic        iq_enq,
    output pci_t        iq_in,
    output pci_t        iq_in1,
    output logic        iq_num_enq,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic        imem_resp,
    input  logic [63:0] imem_rdata,
    output logic [31:0] fetch_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [63:0]  blk_q, blk_d;

    logic [31:0]  pc_plus4;
    logic [31:0]  instr0;
    pci_t         pci0, pci1;

    assign pc_plus4 = pc_q + INSTR_BYTES;
    // An odd-word PC starts in the upper half of the block.
    assign instr0   = pc_q[2] ? blk_q[63:32] : blk_q[31:0];
    assign fetch_pc = pc_q;

    pci_pack u_pack0 (.pc(pc_q),     .instr(instr0),       .pci(pci0));
    pci_pack u_pack1 (.pc(pc_plus4), .instr(blk_q[63:32]), .pci(pci1));

    // Next-state: fetch/push sequencing, redirect handling, reset last so it wins.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        blk_d        = blk_q;
        drain_addr_d = drain_addr_q;
        case (state_q)
            FETCH: begin
                if (flush.valid) begin
                    pc_d = flush.pc;
                    // An outstanding read cannot be cancelled; wait it out at the old address.
                    if (!imem_resp) begin
                        state_d      = DRAIN;
                        drain_addr_d = block_addr(pc_q);
                    end
                end else if (imem_resp) begin
                    blk_d   = imem_rdata;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (flush.valid) begin
                    pc_d    = flush.pc;
                    state_d = FETCH;
                end else if (!iq_full) begin
                    pc_d    = pc_q[2] ? pc_plus4 : pc_q + FETCH_BYTES;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (flush.valid) pc_d = flush.pc;
                if (imem_resp)   state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (rst) begin
            state_d      = FETCH;
            pc_d         = RESET_PC;
            blk_d        = '0;
            drain_addr_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        pc_q         <= pc_d;
        blk_q        <= blk_d;
        drain_addr_q <= drain_addr_d;
    end

    // Outputs decoded from state; reset forces everything idle immediately.
    always_comb begin
        iq_enq     = 1'b0;
        iq_num_enq = 1'b0;
        iq_in      = PCI_IDLE;
        iq_in1     = PCI_IDLE;
        imem_read  = 1'b0;
        imem_addr  = '0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    imem_read = 1'b1;
                    imem_addr = block_addr(pc_q);
                end
                PUSH: begin
                    iq_enq     = !iq_full && !flush.valid;
                    iq_num_enq = !pc_q[2];
                    iq_in      = pci0;
                    if (!pc_q[2]) iq_in1 = pci1;
                end
                DRAIN: begin
                    imem_read = 1'b1;
                    imem_addr = drain_addr_q;
                end
                default: ;
            endcase
        end
    end

endmodule
